if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 27 ++
 rtl/if_inst_fifo.sv | 64 ++++++
 rtl/if_fetch.sv | 127 ++++++++++++
 tb/tb_if_fetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared defines for the instruction-fetch slice: bus widths, reset/enable
// levels, the default boot PC, the fetch FSM states and the buffered
// {addr, inst} entry carried through the instruction FIFO.
package if_fetch_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  localparam logic RstEnable = 1'b0;
  localparam logic Enable    = 1'b1;
  localparam logic Disable   = 1'b0;

  localparam logic [DataW-1:0] ZeroWord = '0;
  localparam logic [AddrW-1:0] ResetPc  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous FIFO of fetched {addr, inst} entries.
// Ports: clk/rst_n (async active-low); clr_i empties the buffer and wins over
// push/pop; push_i/data_i write (accepted when not full or when popping in
// the same cycle); pop_i/data_o read the head; full_o, empty_o, count_o
// report occupancy. DEPTH must be a power of two so pointers wrap naturally.
module if_inst_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage and pointers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{addr: AddrW'(ZeroWord), inst: ZeroWord};
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues sequential fetch requests to a 1-cycle,
// in-order instruction memory, buffers returned words with their PCs and
// hands them to decode; jumps redirect the PC and flush everything pending.
// Ports: clk, rst_n (async active-low); pc_o/pc_send_valid_o/
// pc_receive_ready_i request channel; inst_data_i/inst_valid_i memory
// response; jump_en_i/jump_addr_i redirect; hold_i stall; inst_o/inst_addr_o/
// inst_valid_o/inst_ready_i decode channel.
// pc_send_valid_o is combinational: it must drop in the same cycle as
// hold_i or jump_en_i rises.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [AddrW-1:0] RESET_PC   = ResetPc,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [AddrW-1:0] pc_o,
  output logic             pc_send_valid_o,
  input  logic             pc_receive_ready_i,
  input  logic [DataW-1:0] inst_data_i,
  input  logic             inst_valid_i,
  input  logic             jump_en_i,
  input  logic [AddrW-1:0] jump_addr_i,
  input  logic             hold_i,
  output logic [DataW-1:0] inst_o,
  output logic [AddrW-1:0] inst_addr_o,
  output logic             inst_valid_o,
  input  logic             inst_ready_i
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  fetch_state_e     state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  // live: requests whose words will be kept; drop: requests flushed by a jump
  logic [CntW-1:0]  live_q, live_d, drop_q, drop_d;
  logic [CntW-1:0]  fifo_cnt;
  logic             fifo_full, fifo_empty;
  fetch_entry_t     push_entry, head_entry;
  logic             accept, resp, resp_keep, resp_drop, push, pop;
  logic [SumW-1:0]  outstanding;
  logic             unused_jump_lsb_c;

  assign unused_jump_lsb_c = ^jump_addr_i[1:0];

  assign outstanding     = SumW'(fifo_cnt) + SumW'(live_q) + SumW'(drop_q);
  assign pc_send_valid_o = (state_q == ST_RUN) && !hold_i && !jump_en_i &&
                           (outstanding < SumW'(FIFO_DEPTH));
  assign accept          = pc_send_valid_o && pc_receive_ready_i;

  // Responses with nothing outstanding are stray and ignored; flushed
  // requests are retired first since responses return in order.
  assign resp      = inst_valid_i && ((live_q != '0) || (drop_q != '0));
  assign resp_drop = resp && (drop_q != '0);
  assign resp_keep = resp && (drop_q == '0);

  assign pop  = !fifo_empty && inst_ready_i && !jump_en_i;
  assign push = resp_keep && !jump_en_i && (!fifo_full || pop);

  // Oldest live request sits live_q words behind the current fetch PC.
  assign push_entry = '{addr: pc_q - (AddrW'(live_q) << 2), inst: inst_data_i};

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (jump_en_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign pc_o         = pc_q;
  assign inst_o       = head_entry.inst;
  assign inst_addr_o  = head_entry.addr;
  assign inst_valid_o = fifo_empty ? Disable : Enable;

  // Fetch FSM next state; a redirect always lands in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (hold_i) state_d = ST_HOLD;
      ST_HOLD: if (!hold_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    if (jump_en_i) state_d = ST_RUN;
  end

  // PC and outstanding-request bookkeeping.
  always_comb begin
    pc_d   = pc_q;
    live_d = live_q;
    drop_d = drop_q;
    if (jump_en_i) begin
      pc_d   = {jump_addr_i[AddrW-1:2], 2'b00};
      live_d = '0;
      drop_d = live_q + drop_q - CntW'(resp);
    end else begin
      if (accept) pc_d = pc_q + AddrW'(4);
      live_d = live_q + CntW'(accept) - CntW'(resp_keep);
      drop_d = drop_q - CntW'(resp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      live_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      live_q  <= live_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a 1-cycle memory responder plus a queue-based
// reference of the fetch stage (buffer queue, in-flight queue, expected PC)
// checked every cycle, with directed scenarios and a random phase. A second
// instance boots near the top of the address space to exercise PC wrap.
module tb_if_fetch;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] pc_o;
  logic        pc_send_valid_o;
  logic        pc_receive_ready_i;
  logic [31:0] inst_data_i;
  logic        inst_valid_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  logic        w_rst_n;
  logic [31:0] w_pc_o;
  logic        w_pc_send_valid_o;
  logic [31:0] w_inst_data_i;
  logic        w_inst_valid_i;
  logic [31:0] w_inst_o;
  logic [31:0] w_inst_addr_o;
  logic        w_inst_valid_o;

  if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pc_o               (pc_o),
    .pc_send_valid_o    (pc_send_valid_o),
    .pc_receive_ready_i (pc_receive_ready_i),
    .inst_data_i        (inst_data_i),
    .inst_valid_i       (inst_valid_i),
    .jump_en_i          (jump_en_i),
    .jump_addr_i        (jump_addr_i),
    .hold_i             (hold_i),
    .inst_o             (inst_o),
    .inst_addr_o        (inst_addr_o),
    .inst_valid_o       (inst_valid_o),
    .inst_ready_i       (inst_ready_i)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
    .clk                (clk),
    .rst_n              (w_rst_n),
    .pc_o               (w_pc_o),
    .pc_send_valid_o    (w_pc_send_valid_o),
    .pc_receive_ready_i (1'b1),
    .inst_data_i        (w_inst_data_i),
    .inst_valid_i       (w_inst_valid_i),
    .jump_en_i          (1'b0),
    .jump_addr_i        (32'h0),
    .hold_i             (1'b0),
    .inst_o             (w_inst_o),
    .inst_addr_o        (w_inst_addr_o),
    .inst_valid_o       (w_inst_valid_o),
    .inst_ready_i       (1'b1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference state
  logic [31:0] fq[$];      // buffered addresses, head first
  logic [32:0] ifq[$];     // in-flight {keep, addr}
  logic [31:0] exp_pc;
  bit          boot, held;

  // Memory responder and observation
  bit          resp_pend;
  logic [31:0] resp_data;
  bit          stray_en, force_stray;
  int          acc_cnt;
  logic [31:0] last_acc_pc;
  logic [31:0] seen_dut[$];

  task automatic cycle(input bit mem_rdy, input bit dec_rdy, input bit hold,
                       input bit jmp, input logic [31:0] jaddr);
    bit          exp_v, exp_req, acc_m, acc_d, iv;
    logic [31:0] sent_pc;
    logic [32:0] e;
    pc_receive_ready_i = mem_rdy;
    inst_ready_i       = dec_rdy;
    hold_i             = hold;
    jump_en_i          = jmp;
    jump_addr_i        = jaddr;
    if (resp_pend) begin
      inst_valid_i = 1'b1;
      inst_data_i  = resp_data;
    end else begin
      inst_valid_i = force_stray || (stray_en && ($urandom_range(0, 7) == 0));
      inst_data_i  = $urandom;
    end
    force_stray = 1'b0;
    iv = inst_valid_i;
    #4;
    exp_v = (fq.size() != 0);
    check_eq("inst_valid", 32'(inst_valid_o), 32'(exp_v));
    if (exp_v) begin
      check_eq("inst_addr", inst_addr_o, fq[0]);
      check_eq("inst_data", inst_o, mem_word(fq[0]));
    end
    check_eq("pc", pc_o, exp_pc);
    exp_req = !boot && !held && !hold && !jmp && ((fq.size() + ifq.size()) < DEPTH);
    check_eq("req_valid", 32'(pc_send_valid_o), 32'(exp_req));

    acc_m   = exp_req && mem_rdy;
    acc_d   = pc_send_valid_o && pc_receive_ready_i;
    sent_pc = pc_o;
    if (acc_d) begin
      acc_cnt++;
      last_acc_pc = pc_o;
    end
    if (inst_valid_o && inst_ready_i && !jmp) seen_dut.push_back(inst_addr_o);

    if (jmp) begin
      if (iv && ifq.size() != 0) e = ifq.pop_front();
      fq.delete();
      for (int k = 0; k < ifq.size(); k++) ifq[k][32] = 1'b0;
      exp_pc = {jaddr[31:2], 2'b00};
      boot   = 1'b0;
      held   = 1'b0;
    end else begin
      if (exp_v && dec_rdy) void'(fq.pop_front());
      if (iv && ifq.size() != 0) begin
        e = ifq.pop_front();
        if (e[32]) fq.push_back(e[31:0]);
      end
      if (acc_m) begin
        ifq.push_back({1'b1, exp_pc});
        exp_pc = exp_pc + 32'd4;
      end
      if (boot) boot = 1'b0;
      else if (!held && hold) held = 1'b1;
      else if (held && !hold) held = 1'b0;
    end

    @(posedge clk);
    resp_pend = acc_d;
    resp_data = mem_word(sent_pc);
    @(negedge clk);
  endtask

  // Asserted at a falling edge; outputs are checked before any rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_req_valid", 32'(pc_send_valid_o), 32'h0);
    check_eq("rst_inst_valid", 32'(inst_valid_o), 32'h0);
    check_eq("rst_inst", inst_o, 32'h0);
    check_eq("rst_inst_addr", inst_addr_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fq.delete();
    ifq.delete();
    exp_pc      = 32'h0;
    boot        = 1'b1;
    held        = 1'b0;
    resp_pend   = 1'b0;
    force_stray = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wreq[$];
    logic [31:0] wexp[3];
    logic [31:0] held_pc;
    bit          w_pend, w_acc, w_seen;
    logic [31:0] w_pend_pc, w_acc_pc;
    int          a0, n;

    rst_n = 1'b0; w_rst_n = 1'b0;
    pc_receive_ready_i = 1'b0; inst_data_i = 32'h0; inst_valid_i = 1'b0;
    jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0; inst_ready_i = 1'b0;
    w_inst_data_i = 32'h0; w_inst_valid_i = 1'b0;
    stray_en = 1'b0; force_stray = 1'b0; resp_pend = 1'b0; acc_cnt = 0;
    last_acc_pc = 32'h0; resp_data = 32'h0;
    w_pend = 1'b0; w_pend_pc = 32'h0; w_seen = 1'b0;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;

    // PC wrap from a high boot address, always-ready memory and decode
    @(negedge clk);
    check_eq("wrap_rst_pc", w_pc_o, 32'hFFFF_FFF8);
    w_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w_inst_valid_i = w_pend;
      w_inst_data_i  = mem_word(w_pend_pc);
      #4;
      w_acc    = w_pc_send_valid_o;
      w_acc_pc = w_pc_o;
      if (w_acc) wreq.push_back(w_pc_o);
      if (w_inst_valid_o && !w_seen) begin
        w_seen = 1'b1;
        check_eq("wrap_first_addr", w_inst_addr_o, 32'hFFFF_FFF8);
        check_eq("wrap_first_inst", w_inst_o, mem_word(32'hFFFF_FFF8));
      end
      @(posedge clk);
      w_pend    = w_acc;
      w_pend_pc = w_acc_pc;
      @(negedge clk);
    end
    check_eq("wrap_seen", 32'(w_seen), 32'h1);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("wrap_req%0d", k), (k < wreq.size()) ? wreq[k] : 32'hDEAD_DEAD, wexp[k]);

    // Reset and straight-line fetch
    do_reset();
    seen_dut.delete();
    repeat (30) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("seq%0d", k), (k < seen_dut.size()) ? seen_dut[k] : 32'hDEAD_DEAD, 32'(4 * k));

    // Decode backpressure: buffer fills and fetching stops
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("bp_inst_valid", 32'(inst_valid_o), 32'h1);
    check_eq("bp_req_blocked", 32'(pc_send_valid_o), 32'h0);
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Jump with a request in flight
    n = 0;
    while (!resp_pend && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    check_eq("jmp_inflight", 32'(resp_pend), 32'h1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
    check_eq("jmp_pc", pc_o, 32'h0000_0100);
    check_eq("jmp_flush", 32'(inst_valid_o), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("jmp_lat1_valid", 32'(inst_valid_o), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("jmp_lat2_valid", 32'(inst_valid_o), 32'h1);
    check_eq("jmp_first_addr", inst_addr_o, 32'h0000_0100);
    check_eq("jmp_first_inst", inst_o, mem_word(32'h0000_0100));

    // Hold: no requests, buffer still drains, resume at the held PC
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    held_pc = exp_pc;
    a0 = acc_cnt;
    repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("hold_no_acc", 32'(acc_cnt - a0), 32'h0);
    check_eq("hold_drained", 32'(inst_valid_o), 32'h0);
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 10) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    check_eq("hold_resume_acc", 32'(acc_cnt - a0), 32'h1);
    check_eq("hold_resume_pc", last_acc_pc, held_pc);

    // Jump and hold together: redirect wins and fetch continues at once
    a0 = acc_cnt;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check_eq("jh_pc", pc_o, 32'h0000_0200);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("jh_run_acc", 32'(acc_cnt - a0), 32'h1);
    check_eq("jh_req_pc", last_acc_pc, 32'h0000_0200);

    // Random traffic with stray responses
    stray_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 39) == 0, $urandom);
    end
    stray_en = 1'b0;

    // Reset in mid-operation; a response right after release is dropped
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    seen_dut.delete();
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("mid_rst_first", (seen_dut.size() != 0) ? seen_dut[0] : 32'hDEAD_DEAD, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
